datapath_ctrl: RTL and testbench
================================

# datapath_ctrl

Sequencing controller for the arithmetic datapath. Captures a user-selected operation on a start press and drives the decoder select lines. Pulses the result-register load, then runs the datapath's blink counter. During the blink phase it drives the status LED from the counter's `lt_50` and `lt_200` compare flags for a fixed number of periods. It also services clear-register requests while idle.

## Interface
- `BLINKS`, default 3: number of full `lt_200` periods blinked after each load; legal range 1–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  level, already debounced; a rising edge requests an operation.
- `op`  in  2  operation select `{S_1,S_0}`; sampled on the start edge.
- `reg_clear_req`  in  1  level, already debounced; a rising edge requests a result-register clear.
- `lt_50`  in  1  datapath flag: counter < 50 000 000.
- `lt_200`  in  1  datapath flag: counter < 200 000 000.
- `sign`  in  1  datapath result sign.
- `S_1`, `S_0`  out  1 each  decoder operation select; registered copy of captured `op`.
- `ld`  out  1  result-register load strobe.
- `reg_clr`  out  1  result-register clear strobe.
- `cnt_clr`  out  1  blink-counter clear.
- `cnt_inc`  out  1  blink-counter increment enable.
- `led`  out  1  blink indicator.
- `neg_led`  out  1  negative-result indicator (see Configuration).
- `busy`  out  1  operation in progress.

## Operation
- Moore FSM, 3-bit state register. States: IDLE, RCLR, SETUP, LOAD, BLINK, WRAP.
- Edge detectors on `start` and `reg_clear_req` use a previous-value flop reset to 1. A level held high through reset produces no edge.
- IDLE:
  - Outputs: `cnt_clr`=1; `cnt_inc`, `ld`, `reg_clr`, `busy`, `led` all 0.
  - Start edge: latch `op` into `op_q` and go to SETUP.
  - Clear edge without a start edge: go to RCLR.
  - Both edges in the same cycle: start wins; the clear request is dropped.
- RCLR: `reg_clr`=1 for exactly one cycle, then IDLE.
- SETUP: `busy`=1. One cycle that gives the clocked decoder time to produce the result for `op_q`. Then LOAD.
- LOAD: `busy`=1, `ld`=1 for exactly one cycle, `cnt_clr`=1. Then BLINK. `blink_cnt` (4 bits) is cleared to 0.
- BLINK:
  - Outputs: `busy`=1, `cnt_inc`=1, `cnt_clr`=0.
  - `led` is registered from `lt_50`, so it is high during the first quarter of each period.
  - `lt_200` sampled 0: go to WRAP.
- WRAP: `cnt_clr`=1, `cnt_inc`=0, `led`=0, `blink_cnt` += 1.
  - If `blink_cnt` == BLINKS-1 before the increment: go to IDLE.
  - Otherwise: return to BLINK.
- `S_1`/`S_0` always equal `op_q`. `op_q` changes only on an accepted start edge, so the select lines are stable from SETUP through the end of the blink phase.
- While `busy`=1, start edges and clear edges are ignored (not queued).

## Timing
- Reset (`clr_n`=0 sampled at an edge): state=IDLE, `op_q`=0, `blink_cnt`=0, `led`=0, `neg_led`=0. After that edge, all outputs are 0 except `cnt_clr`=1.
- Reset has priority over every transition and aborts any state, including mid-BLINK.
- All outputs are registered or decoded from state flops. There is no combinational input-to-output path.
- Start edge seen at edge k:
  - `busy` and SETUP from edge k.
  - `ld`=1 in the cycle after edge k+1.
  - Register captures the result at edge k+2; BLINK from edge k+2.
- Period length: one blink period is the counter run plus 1 WRAP cycle. The counter overshoots 200 000 000 by one count before the clear; this is acceptable.
- Total busy time: 2 + BLINKS × (period length) cycles.
- Clear edge at edge k: `reg_clr`=1 in the cycle after edge k; IDLE again from edge k+1.

## Configuration
- `DP_CTRL_SIGN_LED_EN` defined:
  - `neg_led` is loaded from `sign` at the LOAD→BLINK edge and held until the next LOAD or reset.
  - RCLR clears `neg_led` to 0.
- `DP_CTRL_SIGN_LED_EN` undefined: `neg_led` is tied to 0 and `sign` is unused.

## Test plan
The bench uses a stub counter with thresholds of 5 (for `lt_50`) and 20 (for `lt_200`).
- Reset: hold `clr_n`=0 with `start`=1, then release → no operation starts; `busy`=0, `cnt_clr`=1, `S_1`=`S_0`=0.
- Start with `op`=2'b10, BLINKS=3 → `S_1`=1 and `S_0`=0 from edge k; one `ld` pulse at k+1..k+2; 3 WRAP cycles; `led` high 5 cycles per period; `busy` drops after 2+3×22 cycles.
- `start` and `reg_clear_req` rise in the same cycle → the operation runs and `reg_clr` never pulses. A second start edge mid-BLINK → ignored; `op_q` unchanged.
- Clear edge in IDLE → exactly one cycle with `reg_clr`=1; `busy` stays 0.
- `clr_n` pulled low mid-BLINK with count at 12 → IDLE next edge; `led`=0, `cnt_clr`=1, no further `ld`.
- With `DP_CTRL_SIGN_LED_EN` and `sign`=1 at load → `neg_led`=1 through BLINK and after. A later clear edge → `neg_led`=0. Without the macro → `neg_led`=0 throughout.

Source files
------------

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: sequencing controller for the arithmetic datapath.
//
// A rising edge on start latches op and drives the decoder selects. After
// one settle cycle the controller pulses the result-register load. It then
// runs the external blink counter for BLINKS full lt_200 periods, driving
// led from lt_50. A rising edge on reg_clear_req while idle produces a
// one-cycle result-register clear strobe.
//
// Optional feature macro: DP_CTRL_SIGN_LED_EN
//   defined   - neg_led captures sign on the LOAD->BLINK edge and is
//               cleared by a register-clear cycle.
//   undefined - neg_led is tied low and sign is ignored.
//
// Parameters:
//   BLINKS        number of lt_200 periods blinked per load (1..15)
// Ports:
//   clk           system clock, rising edge
//   clr_n         synchronous active-low reset
//   start         debounced level; rising edge requests an operation
//   op[1:0]       operation select, sampled on the start edge
//   reg_clear_req debounced level; rising edge requests a register clear
//   lt_50         counter < 50M flag from the datapath
//   lt_200        counter < 200M flag from the datapath
//   sign          datapath result sign
//   S_1, S_0      decoder select lines (registered op)
//   ld            result-register load strobe
//   reg_clr       result-register clear strobe
//   cnt_clr       blink-counter clear
//   cnt_inc       blink-counter increment enable
//   led           blink indicator
//   neg_led       negative-result indicator
//   busy          operation in progress
module datapath_ctrl #(
  parameter int unsigned BLINKS = 3
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       reg_clear_req,
  input  logic       lt_50,
  input  logic       lt_200,
  input  logic       sign,
  output logic       S_1,
  output logic       S_0,
  output logic       ld,
  output logic       reg_clr,
  output logic       cnt_clr,
  output logic       cnt_inc,
  output logic       led,
  output logic       neg_led,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RCLR  = 3'd1,
    SETUP = 3'd2,
    LOAD  = 3'd3,
    BLINK = 3'd4,
    WRAP  = 3'd5
  } state_t;

  localparam logic [3:0] LAST_BLINK = 4'(BLINKS - 1);

  state_t     state;
  state_t     next_state;
  logic       start_prev;
  logic       clr_prev;
  logic       start_edge;
  logic       clear_edge;
  logic [1:0] op_q;
  logic [3:0] blink_cnt;

  // Previous-value flops reset to 1 so a level held high through reset is
  // not mistaken for a fresh request.
  assign start_edge = start & ~start_prev;
  assign clear_edge = reg_clear_req & ~clr_prev;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ld         = 1'b0;
    reg_clr    = 1'b0;
    cnt_clr    = 1'b1;
    cnt_inc    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        // Start wins over a simultaneous clear; the clear is dropped.
        if (start_edge) begin
          next_state = SETUP;
        end else if (clear_edge) begin
          next_state = RCLR;
        end
      end
      RCLR: begin
        reg_clr    = 1'b1;
        next_state = IDLE;
      end
      SETUP: begin
        busy       = 1'b1;
        next_state = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        ld         = 1'b1;
        next_state = BLINK;
      end
      BLINK: begin
        busy    = 1'b1;
        cnt_inc = 1'b1;
        cnt_clr = 1'b0;
        if (!lt_200) begin
          next_state = WRAP;
        end
      end
      WRAP: begin
        busy = 1'b1;
        if (blink_cnt == LAST_BLINK) begin
          next_state = IDLE;
        end else begin
          next_state = BLINK;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      start_prev <= 1'b1;
      clr_prev   <= 1'b1;
      op_q       <= '0;
      blink_cnt  <= '0;
      led        <= 1'b0;
    end else begin
      // Edges arriving outside IDLE are consumed here and never queued.
      start_prev <= start;
      clr_prev   <= reg_clear_req;
      if (state == IDLE && start_edge) begin
        op_q <= op;
      end
      if (state == LOAD) begin
        blink_cnt <= '0;
      end else if (state == WRAP) begin
        blink_cnt <= blink_cnt + 4'd1;
      end
      led <= (state == BLINK) & lt_50;
    end
  end

  assign S_1 = op_q[1];
  assign S_0 = op_q[0];

`ifdef DP_CTRL_SIGN_LED_EN
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      neg_led <= 1'b0;
    end else if (state == LOAD) begin
      neg_led <= sign;
    end else if (state == RCLR) begin
      neg_led <= 1'b0;
    end
  end
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign neg_led     = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl with a stub blink counter (lt_50 below 5,
// lt_200 below 20). Expected outputs come from the elapsed cycle count
// since an accepted start, using period arithmetic.
module tb_datapath_ctrl;

  localparam int unsigned BLINKS = 3;
  localparam int          PERIOD = 22;
  localparam int          TOTAL  = 2 + BLINKS * PERIOD;
`ifdef DP_CTRL_SIGN_LED_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       reg_clear_req = 1'b0;
  logic       lt_50;
  logic       lt_200;
  logic       sign = 1'b0;
  logic       S_1, S_0, ld, reg_clr, cnt_clr, cnt_inc, led, neg_led, busy;

  int unsigned cnt = 0;

  datapath_ctrl #(.BLINKS(BLINKS)) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .start         (start),
    .op            (op),
    .reg_clear_req (reg_clear_req),
    .lt_50         (lt_50),
    .lt_200        (lt_200),
    .sign          (sign),
    .S_1           (S_1),
    .S_0           (S_0),
    .ld            (ld),
    .reg_clr       (reg_clr),
    .cnt_clr       (cnt_clr),
    .cnt_inc       (cnt_inc),
    .led           (led),
    .neg_led       (neg_led),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr) cnt <= 0;
    else if (cnt_inc) cnt <= cnt + 1;
  end
  assign lt_50  = (cnt < 5);
  assign lt_200 = (cnt < 20);

  // Reference model: t = cycles since accepted start (-1 when idle).
  int         t = -1;
  bit         rclr_m = 1'b0;
  bit         sp = 1'b1;
  bit         cp = 1'b1;
  bit         neg_m = 1'b0;
  logic [1:0] opq_m = 2'b00;

  int checks = 0;
  int errors = 0;
  int n_ld, n_busy, n_led, n_rclr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic check_outputs();
    int p;
    check("busy", 32'(busy), 32'(t >= 0));
    check("ld", 32'(ld), 32'(t == 1));
    check("reg_clr", 32'(reg_clr), 32'(t < 0 && rclr_m));
    check("S_1", 32'(S_1), 32'(opq_m[1]));
    check("S_0", 32'(S_0), 32'(opq_m[0]));
    check("neg_led", 32'(neg_led), 32'(SIGN_EN & neg_m));
    if (t >= 2) begin
      p = (t - 2) % PERIOD;
      check("cnt_inc", 32'(cnt_inc), 32'(p < PERIOD - 1));
      check("cnt_clr", 32'(cnt_clr), 32'(p == PERIOD - 1));
      check("led", 32'(led), 32'(p >= 1 && p <= 5));
    end else begin
      check("cnt_inc", 32'(cnt_inc), 32'd0);
      check("led", 32'(led), 32'd0);
      if (t == 1 || (t < 0 && !rclr_m)) check("cnt_clr", 32'(cnt_clr), 32'd1);
    end
  endtask

  // Called at a falling edge: apply inputs, advance the model over the next
  // rising edge, then compare at the following falling edge.
  task automatic cycle(input bit c, input bit s, input bit r, input logic [1:0] o, input bit sg);
    bit se, ce;
    clr_n = c; start = s; reg_clear_req = r; op = o; sign = sg;
    if (!c) begin
      t = -1; rclr_m = 0; sp = 1; cp = 1; opq_m = 2'b00; neg_m = 0;
    end else begin
      se = s & ~sp;
      ce = r & ~cp;
      if (t >= 0) begin
        if (t == 1) neg_m = sg;
        t++;
        if (t >= TOTAL) t = -1;
      end else if (rclr_m) begin
        rclr_m = 0;
        neg_m  = 0;
      end else if (se) begin
        t = 0;
        opq_m = o;
      end else if (ce) begin
        rclr_m = 1;
      end
      sp = s;
      cp = r;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    n_ld   += int'(ld);
    n_busy += int'(busy);
    n_led  += int'(led);
    n_rclr += int'(reg_clr);
  endtask

  task automatic clear_tallies();
    n_ld = 0; n_busy = 0; n_led = 0; n_rclr = 0;
  endtask

  initial begin
    bit s, r, c;
    @(negedge clk);

    // Reset with start held high; release must not start anything.
    repeat (3) cycle(0, 1, 0, 2'b11, 0);
    clear_tallies();
    repeat (5) cycle(1, 1, 0, 2'b11, 0);
    check("rst_no_busy", 32'(n_busy), 32'd0);
    cycle(1, 0, 0, 2'b00, 0);

    // Start and clear rising together, op=10, sign=1; second start mid-BLINK.
    clear_tallies();
    cycle(1, 1, 1, 2'b10, 1);
    for (int i = 0; i < 200 && t >= 0; i++) begin
      cycle(1, (i != 30), 1, (i > 30) ? 2'b01 : 2'b10, 1);
    end
    check("op_busy_cycles", 32'(n_busy), 32'(TOTAL));
    check("op_ld_pulses", 32'(n_ld), 32'd1);
    check("op_led_cycles", 32'(n_led), 32'(5 * BLINKS));
    check("op_no_rclr", 32'(n_rclr), 32'd0);
    check("op_sel_kept", 32'({S_1, S_0}), 32'b10);
    check("neg_after_op", 32'(neg_led), 32'(SIGN_EN));

    // Clear edge in idle.
    cycle(1, 0, 0, 2'b00, 0);
    clear_tallies();
    cycle(1, 0, 1, 2'b00, 0);
    repeat (4) cycle(1, 0, 1, 2'b00, 0);
    check("clr_pulses", 32'(n_rclr), 32'd1);
    check("clr_no_busy", 32'(n_busy), 32'd0);
    check("neg_after_clr", 32'(neg_led), 32'd0);

    // Abort mid-BLINK with the stub counter at 12.
    cycle(1, 0, 0, 2'b00, 0);
    cycle(1, 1, 0, 2'b01, 0);
    for (int i = 0; i < 40 && t != 14; i++) cycle(1, 1, 0, 2'b01, 0);
    check("cnt_at_abort", cnt, 32'd12);
    cycle(0, 1, 0, 2'b01, 0);
    clear_tallies();
    repeat (6) cycle(1, 1, 0, 2'b01, 0);
    check("abort_no_ld", 32'(n_ld), 32'd0);
    check("abort_no_busy", 32'(n_busy), 32'd0);

    // Randomized traffic.
    s = 1; r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) s = ~s;
      if ($urandom_range(9) == 0) r = ~r;
      c = ($urandom_range(299) != 0);
      cycle(c, s, r, 2'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
